bit_frame_tx: RTL



---
 rtl/bit_frame_tx_if.sv | 13 +
 rtl/bit_frame_tx.sv | 99 +++++++++
 2 files changed

// File: rtl/bit_frame_tx_if.sv
// bit_frame_tx_if: parallel handshake in, serial line and frame status out
interface bit_frame_tx_if #(
  parameter int WIDTH = 2
);
  logic i_valid;
  logic [WIDTH-1:0] i_data;
  logic o_ready;
  logic o_ser;
  logic o_busy;
  logic o_done;
  modport master (output i_valid, i_data, input o_ready, o_ser, o_busy, o_done);
  modport slave (input i_valid, i_data, output o_ready, o_ser, o_busy, o_done);
endinterface

// File: rtl/bit_frame_tx.sv
// bit_frame_tx: start/data(LSB first)/stop serial framer, DIV clocks per bit; define BIT_FRAME_TX_PARITY_EN for an even-parity bit before stop
module bit_frame_tx #(
  parameter int WIDTH = 2,
  parameter int DIV = 1
) (
  input logic clk,
  input logic reset,
  bit_frame_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV - 1);
`ifdef BIT_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] div, div_n;
  logic ser, ser_n, busy, done, last;
`ifdef BIT_FRAME_TX_PARITY_EN
  logic par, par_n;
`endif
  assign last = div == 8'd0;
  assign bus.o_ready = state == IDLE && !reset;
  assign bus.o_ser = ser;
  assign bus.o_busy = busy;
  assign bus.o_done = done;
  // next state, shift/count/divider updates and the serial level for the next cycle
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n = cnt;
    div_n = last ? DIV_LOAD : div - 8'd1;
`ifdef BIT_FRAME_TX_PARITY_EN
    par_n = par;
`endif
    case (state)
      IDLE: begin
        div_n = DIV_LOAD;
        if (bus.i_valid) begin
          state_n = START;
          shift_n = bus.i_data;
          cnt_n = '0;
`ifdef BIT_FRAME_TX_PARITY_EN
          par_n = ^bus.i_data;
`endif
        end
      end
      START: state_n = last ? DATA : state;
      DATA: if (last) begin
        shift_n = shift >> 1;
        cnt_n = cnt + 1'b1;
`ifdef BIT_FRAME_TX_PARITY_EN
        state_n = cnt == CW'(WIDTH - 1) ? PARITY : state;
`else
        state_n = cnt == CW'(WIDTH - 1) ? STOP : state;
`endif
      end
`ifdef BIT_FRAME_TX_PARITY_EN
      PARITY: state_n = last ? STOP : state;
`endif
      STOP: state_n = last ? IDLE : state;
      default: state_n = IDLE;
    endcase
`ifdef BIT_FRAME_TX_PARITY_EN
    ser_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
`else
    ser_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`endif
  end
  // state and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      cnt <= '0;
      div <= '0;
      ser <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef BIT_FRAME_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shift <= shift_n;
      cnt <= cnt_n;
      div <= div_n;
      ser <= ser_n;
      busy <= state_n != IDLE;
      done <= state_n == STOP && div_n == 8'd0;
`ifdef BIT_FRAME_TX_PARITY_EN
      par <= par_n;
`endif
    end
  end
endmodule
